// File: rtl/vga_vram_arbiter.sv
// Shares one synchronous-read video-RAM port between display scan-out, a clear engine and a posted-write FIFO.
// Sync and active-area signals are delayed two cycles so they line up with the pixel colour at the DAC.
module vga_vram_arbiter #(
  parameter int FB_W        = 80,
  parameter int FB_H        = 60,
  parameter int SCALE_SHIFT = 3,
  parameter int DATA_W      = 3,
  parameter int ADDR_W      = 13,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_activeArea,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic [9:0]        i_px,
  input  logic [9:0]        i_py,
  input  logic              i_wrValid,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  output logic              o_wrReady,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_clearColor,
  output logic              o_busy,
  output logic              o_dropped,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memWe,
  output logic [DATA_W-1:0] o_memWdata,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic [DATA_W-1:0] o_rgb,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_activeArea
);

  localparam int                FB_CELLS  = FB_W * FB_H;
  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_CELLS - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_clear_addr;
  logic [DATA_W-1:0]   r_clear_color;
  logic                w_grant_disp, w_grant_clear, w_grant_fifo;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_count, w_count_next;
  logic                r_wr_ready;
  logic                w_push, w_pop, w_empty, w_head_in_range;

  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_busy, r_dropped;
  logic                r_act_d1, r_act_d2, r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2;

  logic [ADDR_W-1:0]   w_cell_x, w_cell_y, w_disp_addr;

  assign w_cell_x    = ADDR_W'(i_px >> SCALE_SHIFT);
  assign w_cell_y    = ADDR_W'(i_py >> SCALE_SHIFT);
  assign w_disp_addr = w_cell_y * ADDR_W'(FB_W) + w_cell_x;

  assign w_empty         = (r_count == '0);
  assign w_push          = i_wrValid & r_wr_ready;
  assign w_pop           = w_grant_fifo;
  // Extra bit keeps the compare correct when the framebuffer fills the whole address space.
  assign w_head_in_range = ({1'b0, r_fifo_addr[r_rd_ptr]} < (ADDR_W + 1)'(FB_CELLS));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_clear) w_next_state = S_CLEAR;
      S_CLEAR: if (w_grant_clear && r_clear_addr == LAST_ADDR) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fixed priority: scan-out, then clear, then FIFO head.
  always_comb begin
    w_grant_disp  = 1'b0;
    w_grant_clear = 1'b0;
    w_grant_fifo  = 1'b0;
    if (i_activeArea)             w_grant_disp  = 1'b1;
    else if (r_state == S_CLEAR)  w_grant_clear = 1'b1;
    else if (!w_empty)            w_grant_fifo  = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clear_addr  <= '0;
      r_clear_color <= '0;
    end else if (r_state == S_IDLE && i_clear) begin
      r_clear_addr  <= '0;
      r_clear_color <= i_clearColor;
    end else if (w_grant_clear && r_clear_addr != LAST_ADDR) begin
      r_clear_addr  <= r_clear_addr + 1'b1;
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: FIFO storage has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_wrAddr;
      r_fifo_data[r_wr_ptr] <= i_wrData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_wr_ready <= (w_count_next != FULL_CNT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_dropped   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_dropped <= 1'b0;
      r_busy    <= (w_next_state == S_CLEAR);
      if (w_grant_disp) begin
        r_mem_addr <= w_disp_addr;
      end else if (w_grant_clear) begin
        r_mem_addr  <= r_clear_addr;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= r_clear_color;
      end else if (w_grant_fifo) begin
        if (w_head_in_range) begin
          r_mem_addr  <= r_fifo_addr[r_rd_ptr];
          r_mem_we    <= 1'b1;
          r_mem_wdata <= r_fifo_data[r_rd_ptr];
        end else begin
          r_dropped <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      {r_act_d1, r_act_d2, r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2} <= '0;
    end else begin
      r_act_d1 <= i_activeArea;
      r_act_d2 <= r_act_d1;
      r_hs_d1  <= i_hs;
      r_hs_d2  <= r_hs_d1;
      r_vs_d1  <= i_vs;
      r_vs_d2  <= r_vs_d1;
    end
  end

  assign o_memAddr    = r_mem_addr;
  assign o_memWe      = r_mem_we;
  assign o_memWdata   = r_mem_wdata;
  assign o_wrReady    = r_wr_ready;
  assign o_busy       = r_busy;
  assign o_dropped    = r_dropped;
  assign o_hs         = r_hs_d2;
  assign o_vs         = r_vs_d2;
  assign o_activeArea = r_act_d2;
  assign o_rgb        = r_act_d2 ? i_memRdata : '0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: a display-pipeline vector table plus hand-written
// sequences for FIFO fill/drain, out-of-range drop, full clear and reset mid-clear.
module tb_vga_vram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 3;

  logic              clk = 1'b0;
  logic              i_reset, i_activeArea, i_hs, i_vs;
  logic [9:0]        i_px, i_py;
  logic              i_wrValid;
  logic [ADDR_W-1:0] i_wrAddr;
  logic [DATA_W-1:0] i_wrData;
  logic              o_wrReady;
  logic              i_clear;
  logic [DATA_W-1:0] i_clearColor;
  logic              o_busy, o_dropped;
  logic [ADDR_W-1:0] o_memAddr;
  logic              o_memWe;
  logic [DATA_W-1:0] o_memWdata;
  logic [DATA_W-1:0] i_memRdata;
  logic [DATA_W-1:0] o_rgb;
  logic              o_hs, o_vs, o_activeArea;

  always #5 clk = ~clk;

  vga_vram_arbiter #(
    .FB_W(80), .FB_H(60), .SCALE_SHIFT(3), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_activeArea(i_activeArea), .i_hs(i_hs), .i_vs(i_vs),
    .i_px(i_px), .i_py(i_py), .i_wrValid(i_wrValid), .i_wrAddr(i_wrAddr), .i_wrData(i_wrData),
    .o_wrReady(o_wrReady), .i_clear(i_clear), .i_clearColor(i_clearColor), .o_busy(o_busy),
    .o_dropped(o_dropped), .o_memAddr(o_memAddr), .o_memWe(o_memWe), .o_memWdata(o_memWdata),
    .i_memRdata(i_memRdata), .o_rgb(o_rgb), .o_hs(o_hs), .o_vs(o_vs), .o_activeArea(o_activeArea)
  );

  typedef struct {
    logic              act, hs, vs;
    logic [9:0]        px, py;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_rgb;
    logic              e_hs, e_vs, e_act;
  } vec_t;

  vec_t vecs [7];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   exp_caddr, bad_clear, active_writes, busy_errs, stray;
  logic prev_act, clear_done, got_fifo, found;

  initial begin
    // Rows: inputs of cycle k, expected outputs seen in cycle k (pipeline of 1/2 cycles).
    vecs[0] = '{1'b1, 1'b1, 1'b0, 10'd17,  10'd9,   3'b000, 13'd0,    3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 10'd639, 10'd479, 3'b000, 13'd82,   3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 10'd8,   10'd8,   3'b101, 13'd4799, 3'b101, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 10'd0,   10'd0,   3'b011, 13'd81,   3'b011, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   3'b111, 13'd81,   3'b111, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   3'b110, 13'd81,   3'b000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   3'b000, 13'd81,   3'b000, 1'b0, 1'b0, 1'b0};

    i_reset = 1'b1; i_activeArea = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_px = '0; i_py = '0;
    i_wrValid = 1'b0; i_wrAddr = '0; i_wrData = '0; i_clear = 1'b0; i_clearColor = '0;
    i_memRdata = '0;

    // Reset held for three edges, then released.
    tick(); tick(); tick();
    i_reset = 1'b0;
    #1;
    check("rst_memAddr", o_memAddr, 0);
    check("rst_memWe", o_memWe, 0);
    check("rst_memWdata", o_memWdata, 0);
    check("rst_rgb", o_rgb, 0);
    check("rst_hs", o_hs, 0);
    check("rst_vs", o_vs, 0);
    check("rst_active", o_activeArea, 0);
    check("rst_busy", o_busy, 0);
    check("rst_dropped", o_dropped, 0);
    check("rst_wrReady", o_wrReady, 0);
    tick();
    #1;
    check("wrReady_after_release", o_wrReady, 1);
    tick();

    // Display pipeline table.
    for (int i = 0; i < 7; i++) begin
      i_activeArea = vecs[i].act; i_hs = vecs[i].hs; i_vs = vecs[i].vs;
      i_px = vecs[i].px; i_py = vecs[i].py; i_memRdata = vecs[i].rd;
      #1;
      check($sformatf("v%0d_memAddr", i), o_memAddr, vecs[i].e_addr);
      check($sformatf("v%0d_memWe", i), o_memWe, 0);
      check($sformatf("v%0d_rgb", i), o_rgb, vecs[i].e_rgb);
      check($sformatf("v%0d_hs", i), o_hs, vecs[i].e_hs);
      check($sformatf("v%0d_vs", i), o_vs, vecs[i].e_vs);
      check($sformatf("v%0d_active", i), o_activeArea, vecs[i].e_act);
      tick();
    end
    i_memRdata = '0;

    // Posted writes queued during the active area, drained in blanking.
    for (int i = 0; i < 4; i++) begin
      i_activeArea = 1'b1; i_wrValid = 1'b1;
      i_wrAddr = ADDR_W'(10 + i); i_wrData = DATA_W'(i + 1);
      #1;
      check("fill_wrReady", o_wrReady, 1);
      check("fill_no_write", o_memWe, 0);
      tick();
    end
    i_wrAddr = 13'd99; i_wrData = 3'd7;
    #1;
    check("full_wrReady", o_wrReady, 0);
    check("full_no_write", o_memWe, 0);
    tick();
    i_activeArea = 1'b0; i_wrValid = 1'b0;
    #1;
    check("full_wrReady_hold", o_wrReady, 0);
    check("drain_wait", o_memWe, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_we", o_memWe, 1);
      check("drain_addr", o_memAddr, 10 + i);
      check("drain_data", o_memWdata, i + 1);
      check("drain_wrReady", o_wrReady, 1);
      tick();
    end
    #1;
    check("drain_done_no_write", o_memWe, 0);
    tick();

    // Out-of-range write dropped, next in-range write goes through.
    i_wrValid = 1'b1; i_wrAddr = 13'd4800; i_wrData = 3'd7;
    #1;
    check("oor_dropped_idle", o_dropped, 0);
    tick();
    i_wrAddr = 13'd4799; i_wrData = 3'd6;
    #1;
    check("oor_dropped_early", o_dropped, 0);
    check("oor_we_early", o_memWe, 0);
    tick();
    i_wrValid = 1'b0;
    #1;
    check("oor_dropped", o_dropped, 1);
    check("oor_we", o_memWe, 0);
    tick();
    #1;
    check("oor_dropped_pulse", o_dropped, 0);
    check("last_cell_we", o_memWe, 1);
    check("last_cell_addr", o_memAddr, 4799);
    check("last_cell_data", o_memWdata, 6);
    tick();
    #1;
    check("last_cell_once", o_memWe, 0);
    tick();

    // Full clear while the FIFO holds addr 5; clear wins every blanking cycle.
    i_activeArea = 1'b1; i_wrValid = 1'b1; i_wrAddr = 13'd5; i_wrData = 3'b100;
    #1;
    tick();
    i_wrValid = 1'b0; i_clear = 1'b1; i_clearColor = 3'b010;
    #1;
    check("clr_busy_before", o_busy, 0);
    tick();
    exp_caddr = 0; bad_clear = 0; active_writes = 0; busy_errs = 0;
    prev_act = 1'b1; clear_done = 1'b0; got_fifo = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      i_activeArea = ((cyc % 5) < 2);
      i_clear      = (cyc == 100);
      i_clearColor = 3'b111;
      #1;
      if (cyc == 0) check("clr_busy", o_busy, 1);
      if (o_memWe && prev_act) active_writes++;
      if (o_memWe) begin
        if (!clear_done) begin
          if (o_memAddr !== ADDR_W'(exp_caddr) || o_memWdata !== 3'b010) bad_clear++;
          if (exp_caddr == 4799) begin
            check("clr_busy_fall", o_busy, 0);
            clear_done = 1'b1;
          end else if (o_busy !== 1'b1) begin
            busy_errs++;
          end
          exp_caddr++;
        end else begin
          check("fifo_after_clear_addr", o_memAddr, 5);
          check("fifo_after_clear_data", o_memWdata, 3'b100);
          got_fifo = 1'b1;
        end
      end else if (!clear_done && o_busy !== 1'b1) begin
        busy_errs++;
      end
      prev_act = i_activeArea;
      tick();
      if (got_fifo) break;
    end
    i_activeArea = 1'b0; i_clear = 1'b0;
    check("clr_finished_in_budget", got_fifo, 1);
    check("clr_write_count", exp_caddr, 4800);
    check("clr_bad_writes", bad_clear, 0);
    check("writes_during_active", active_writes, 0);
    check("clr_busy_errors", busy_errs, 0);
    #1;
    check("clr_idle_after", o_busy, 0);
    tick();

    // Reset in the middle of a clear, with entries pending in the FIFO.
    i_clear = 1'b1; i_clearColor = 3'b001;
    #1;
    tick();
    i_clear = 1'b0; i_wrValid = 1'b1; i_wrAddr = 13'd20; i_wrData = 3'd2;
    #1;
    check("rclr_busy", o_busy, 1);
    check("rclr_wrReady", o_wrReady, 1);
    tick();
    i_wrAddr = 13'd21;
    #1;
    tick();
    i_wrValid = 1'b0;
    #1;
    check("rclr_push_accepted", o_wrReady, 1);
    tick();
    found = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      if (o_memWe && o_memAddr == 13'd1000) begin
        found = 1'b1;
        check("rclr_data", o_memWdata, 3'b001);
      end
      tick();
      if (found) break;
    end
    check("rclr_reached_1000", found, 1);
    i_reset = 1'b1;
    #1;
    tick();
    #1;
    check("rclr_busy_in_reset", o_busy, 0);
    check("rclr_we_in_reset", o_memWe, 0);
    check("rclr_wrReady_in_reset", o_wrReady, 0);
    tick();
    i_reset = 1'b0;
    #1;
    tick();
    stray = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (cyc == 0) check("rclr_wrReady_after", o_wrReady, 1);
      if (o_memWe || o_busy) stray++;
      tick();
    end
    check("rclr_no_activity_after", stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
